// File: rtl/sha256_round_sequencer_if.sv
// Block-in / digest-out handshake plus the bus to the shared combinational round datapath.
// first_blk exists only when SEQ_IV_EN is defined.
interface sha256_round_sequencer_if;
    logic             in_valid;
    logic             in_ready;
    logic [511:0]     msg_in;
    logic [7:0][31:0] chain_in;
`ifdef SEQ_IV_EN
    logic             first_blk;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [7:0][31:0] digest_out;
    logic             cmp_in_valid;
    logic [7:0][31:0] cmp_hash_in;
    logic [31:0]      cmp_ki;
    logic [31:0]      cmp_wi;
    logic [7:0][31:0] cmp_hash_out;

`ifdef SEQ_IV_EN
    modport slave (
        input  in_valid, msg_in, chain_in, first_blk, out_ready, cmp_hash_out,
        output in_ready, out_valid, digest_out, cmp_in_valid, cmp_hash_in, cmp_ki, cmp_wi
    );
    modport master (
        output in_valid, msg_in, chain_in, first_blk, out_ready, cmp_hash_out,
        input  in_ready, out_valid, digest_out, cmp_in_valid, cmp_hash_in, cmp_ki, cmp_wi
    );
`else
    modport slave (
        input  in_valid, msg_in, chain_in, out_ready, cmp_hash_out,
        output in_ready, out_valid, digest_out, cmp_in_valid, cmp_hash_in, cmp_ki, cmp_wi
    );
    modport master (
        output in_valid, msg_in, chain_in, out_ready, cmp_hash_out,
        input  in_ready, out_valid, digest_out, cmp_in_valid, cmp_hash_in, cmp_ki, cmp_wi
    );
`endif
endinterface

// File: rtl/sha256_round_sequencer.sv
// Sequences one shared SHA-256 round through ROUNDS rounds per block; optional SEQ_IV_EN selects the FIPS IV on first_blk.
// Latency: accept at edge N, digest registered and out_valid high from edge N+ROUNDS+1.
// Backpressure: one block in flight; in_ready low until the digest handshake completes, digest held while out_ready low.
module sha256_round_sequencer #(
    parameter int ROUNDS = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sha256_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t           state, state_nxt;
    logic [5:0]       t;
    logic [7:0][31:0] chain, work, digest, seed;
    logic [31:0]      w [16];
    logic [31:0]      w_next;
    logic             accept, in_round, in_rdy, out_vld;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef SEQ_IV_EN
    localparam logic [7:0][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    assign seed = bus.first_blk ? IV : bus.chain_in;
`else
    assign seed = bus.chain_in;
`endif

    // The window always holds W[t..t+15]; the new tail word is W[t+16].
    assign w_next = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        in_round  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                in_round = 1'b1;
                if (t == T_LAST) state_nxt = FINAL;
            end
            FINAL: state_nxt = DONE;
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t      <= '0;
            chain  <= '0;
            work   <= '0;
            digest <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else if (accept) begin
            t     <= '0;
            chain <= seed;
            work  <= seed;
            for (int i = 0; i < 16; i++) w[i] <= bus.msg_in[511 - 32*i -: 32];
        end else if (in_round) begin
            t    <= t + 6'd1;
            work <= bus.cmp_hash_out;
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_next;
        end else if (state == FINAL) begin
            for (int i = 0; i < 8; i++) digest[i] <= chain[i] + work[i];
        end
    end

    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = out_vld;
    assign bus.digest_out   = digest;
    assign bus.cmp_in_valid = in_round;
    assign bus.cmp_hash_in  = in_round ? work : '0;
    assign bus.cmp_ki       = in_round ? K[t] : '0;
    assign bus.cmp_wi       = in_round ? w[0] : '0;
endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Directed bench: the sequencer drives a behavioural SHA-256 round; "abc" block checked against the known digest.
module tb_sha256_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_round_sequencer_if bus();

    sha256_round_sequencer #(.ROUNDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [7:0][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [7:0][31:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [511:0] ABC_MSG = {32'h61626380, 448'h0, 32'h00000018};
    localparam int BUDGET = 300;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] round_model(input logic [7:0][31:0] s,
                                                     input logic [31:0] k, input logic [31:0] wv);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [7:0][31:0] r;
        a = s[7]; b = s[6]; c = s[5]; d = s[4];
        e = s[3]; f = s[2]; g = s[1]; h = s[0];
        t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + wv;
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        r[7] = t1 + t2; r[6] = a; r[5] = b; r[4] = c;
        r[3] = d + t1;  r[2] = e; r[1] = f; r[0] = g;
        return r;
    endfunction

    always_comb bus.cmp_hash_out = round_model(bus.cmp_hash_in, bus.cmp_ki, bus.cmp_wi);

    int cyc = 0;
    int acc_cnt = 0;
    int xfer_cnt = 0;
    int acc_cyc [$];
    logic [7:0][31:0] last_dig = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc.push_back(cyc);
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            xfer_cnt <= xfer_cnt + 1;
            last_dig <= bus.digest_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input logic [511:0] m, input logic [7:0][31:0] ch);
        int n;
        n = 0;
        bus.msg_in   = m;
        bus.chain_in = ch;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        vectors++;
        if (n >= BUDGET) begin
            miscompares++;
            $display("FAIL accept_timeout: in_ready still %0b after %0d cycles, want 1", bus.in_ready, n);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < BUDGET) begin
            step();
            lat++;
        end
        vectors++;
        if (lat >= BUDGET) begin
            miscompares++;
            $display("FAIL out_valid_timeout: out_valid still %0b after %0d cycles, want 1", bus.out_valid, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        vectors++; if (bus.cmp_in_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cmp_in_valid: got %0b want 0", bus.cmp_in_valid); end
        vectors++; if (bus.digest_out !== '0) begin miscompares++; $display("FAIL reset_digest: got %h want 0", bus.digest_out); end
        vectors++; if (bus.cmp_hash_in !== '0) begin miscompares++; $display("FAIL reset_cmp_hash_in: got %h want 0", bus.cmp_hash_in); end
        vectors++; if (bus.cmp_ki !== 32'h0 || bus.cmp_wi !== 32'h0) begin miscompares++; $display("FAIL reset_ki_wi: got %h/%h want 0/0", bus.cmp_ki, bus.cmp_wi); end
        repeat (3) step();
        rst_n = 1'b1;
        step();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_in_ready: got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_abc();
        int lat;
        int x0;
        logic [31:0] exp_w;
        x0 = xfer_cnt;
        bus.out_ready = 1'b1;
        accept_block(ABC_MSG, IV);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL round_in_ready: got %0b want 0", bus.in_ready); end
        vectors++; if (bus.cmp_hash_in !== IV) begin miscompares++; $display("FAIL round0_hash_in: got %h want %h", bus.cmp_hash_in, IV); end
        vectors++; if (bus.cmp_ki !== 32'h428a2f98) begin miscompares++; $display("FAIL k0: got %h want 428a2f98", bus.cmp_ki); end
        for (int k = 0; k <= 16; k++) begin
            exp_w = (k == 0 || k == 16) ? 32'h61626380 : (k == 15 ? 32'h00000018 : 32'h0);
            vectors++; if (bus.cmp_in_valid !== 1'b1) begin miscompares++; $display("FAIL cmp_in_valid_t%0d: got %0b want 1", k, bus.cmp_in_valid); end
            vectors++; if (bus.cmp_wi !== exp_w) begin miscompares++; $display("FAIL w_t%0d: got %h want %h", k, bus.cmp_wi, exp_w); end
            if (k == 1) begin
                vectors++; if (bus.cmp_ki !== 32'h71374491) begin miscompares++; $display("FAIL k1: got %h want 71374491", bus.cmp_ki); end
            end
            step();
        end
        wait_valid(lat);
        lat += 17;
        vectors++; if (lat !== 65) begin miscompares++; $display("FAIL abc_latency: got %0d want 65", lat); end
        vectors++; if (bus.digest_out !== ABC_DIG) begin miscompares++; $display("FAIL abc_digest: got %h want %h", bus.digest_out, ABC_DIG); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL done_in_ready: got %0b want 0", bus.in_ready); end
        vectors++; if (bus.cmp_in_valid !== 1'b0 || bus.cmp_wi !== 32'h0 || bus.cmp_ki !== 32'h0) begin
            miscompares++; $display("FAIL done_cmp_idle: got v=%0b w=%h k=%h want 0/0/0", bus.cmp_in_valid, bus.cmp_wi, bus.cmp_ki); end
        step();
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL abc_return_idle: got ov=%0b ir=%0b want 0/1", bus.out_valid, bus.in_ready); end
        vectors++; if (xfer_cnt !== x0 + 1) begin miscompares++; $display("FAIL abc_xfer_count: got %0d want %0d", xfer_cnt - x0, 1); end
    endtask

    task automatic test_backpressure();
        int lat;
        int x0;
        x0 = xfer_cnt;
        bus.out_ready = 1'b0;
        accept_block(ABC_MSG, IV);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                miscompares++; $display("FAIL hold_flags_%0d: got ov=%0b ir=%0b want 1/0", i, bus.out_valid, bus.in_ready); end
            vectors++; if (bus.digest_out !== ABC_DIG) begin miscompares++; $display("FAIL hold_digest_%0d: got %h want %h", i, bus.digest_out, ABC_DIG); end
        end
        vectors++; if (xfer_cnt !== x0) begin miscompares++; $display("FAIL hold_no_xfer: got %0d want 0", xfer_cnt - x0); end
        bus.out_ready = 1'b1;
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL release_out_valid: got %0b want 0", bus.out_valid); end
        vectors++; if (last_dig !== ABC_DIG) begin miscompares++; $display("FAIL release_digest: got %h want %h", last_dig, ABC_DIG); end
        step();
        vectors++; if (xfer_cnt !== x0 + 1) begin miscompares++; $display("FAIL release_single_xfer: got %0d want 1", xfer_cnt - x0); end
    endtask

    task automatic test_ignore_in_valid();
        int lat;
        int a0;
        bus.out_ready = 1'b0;
        accept_block(ABC_MSG, IV);
        a0 = acc_cnt;
        repeat (5) step();
        bus.msg_in   = {16{32'hdeadbeef}};
        bus.chain_in = '1;
        bus.in_valid = 1'b1;
        repeat (10) step();
        repeat (3) begin
            bus.in_valid = 1'b0;
            step();
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        vectors++; if (acc_cnt !== a0) begin miscompares++; $display("FAIL round_no_accept: got %0d extra accepts want 0", acc_cnt - a0); end
        wait_valid(lat);
        vectors++; if (bus.digest_out !== ABC_DIG) begin miscompares++; $display("FAIL ignore_digest: got %h want %h", bus.digest_out, ABC_DIG); end
        bus.msg_in   = ABC_MSG;
        bus.chain_in = IV;
        bus.in_valid = 1'b1;
        repeat (3) step();
        vectors++; if (bus.in_ready !== 1'b0 || acc_cnt !== a0) begin
            miscompares++; $display("FAIL done_no_accept: got ir=%0b extra=%0d want 0/0", bus.in_ready, acc_cnt - a0); end
        bus.out_ready = 1'b1;
        step();
        vectors++; if (acc_cnt !== a0) begin miscompares++; $display("FAIL no_overlap: got %0d extra accepts want 0", acc_cnt - a0); end
        step();
        bus.in_valid = 1'b0;
        vectors++; if (acc_cnt !== a0 + 1) begin miscompares++; $display("FAIL accept_after_xfer: got %0d accepts want 1", acc_cnt - a0); end
        wait_valid(lat);
        vectors++; if (bus.digest_out !== ABC_DIG) begin miscompares++; $display("FAIL next_block_digest: got %h want %h", bus.digest_out, ABC_DIG); end
        step();
    endtask

    task automatic test_reset_mid_round();
        int lat;
        bus.out_ready = 1'b1;
        accept_block(ABC_MSG, IV);
        repeat (30) step();
        vectors++; if (bus.cmp_in_valid !== 1'b1) begin miscompares++; $display("FAIL mid_round_active: got %0b want 1", bus.cmp_in_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL async_reset_flags: got ov=%0b ir=%0b want 0/1", bus.out_valid, bus.in_ready); end
        vectors++; if (bus.cmp_in_valid !== 1'b0 || bus.cmp_wi !== 32'h0) begin
            miscompares++; $display("FAIL async_reset_cmp: got v=%0b w=%h want 0/0", bus.cmp_in_valid, bus.cmp_wi); end
        vectors++; if (bus.digest_out !== '0) begin miscompares++; $display("FAIL async_reset_digest: got %h want 0", bus.digest_out); end
        step();
        rst_n = 1'b1;
        step();
        accept_block(ABC_MSG, IV);
        wait_valid(lat);
        vectors++; if (lat !== 65) begin miscompares++; $display("FAIL post_reset_latency: got %0d want 65", lat); end
        vectors++; if (bus.digest_out !== ABC_DIG) begin miscompares++; $display("FAIL post_reset_digest: got %h want %h", bus.digest_out, ABC_DIG); end
        step();
    endtask

    task automatic test_back_to_back();
        int a0;
        int x0;
        int n;
        int lat;
        a0 = acc_cnt;
        x0 = xfer_cnt;
        bus.out_ready = 1'b1;
        bus.msg_in    = ABC_MSG;
        bus.chain_in  = IV;
        bus.in_valid  = 1'b1;
        n = 0;
        while (acc_cnt < a0 + 3 && n < 4 * BUDGET) begin
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (acc_cnt < a0 + 3) begin
            miscompares++; $display("FAIL b2b_accepts: got %0d want 3", acc_cnt - a0);
        end else begin
            vectors++; if (acc_cyc[a0+1] - acc_cyc[a0] !== 67) begin miscompares++; $display("FAIL b2b_spacing_1: got %0d want 67", acc_cyc[a0+1] - acc_cyc[a0]); end
            vectors++; if (acc_cyc[a0+2] - acc_cyc[a0+1] !== 67) begin miscompares++; $display("FAIL b2b_spacing_2: got %0d want 67", acc_cyc[a0+2] - acc_cyc[a0+1]); end
        end
        wait_valid(lat);
        step();
        vectors++; if (xfer_cnt !== x0 + 3) begin miscompares++; $display("FAIL b2b_xfers: got %0d want 3", xfer_cnt - x0); end
        vectors++; if (last_dig !== ABC_DIG) begin miscompares++; $display("FAIL b2b_digest: got %h want %h", last_dig, ABC_DIG); end
    endtask

`ifdef SEQ_IV_EN
    task automatic test_iv();
        int lat;
        bus.out_ready = 1'b1;
        bus.first_blk = 1'b1;
        accept_block(ABC_MSG, '1);
        bus.first_blk = 1'b0;
        wait_valid(lat);
        vectors++; if (bus.digest_out !== ABC_DIG) begin miscompares++; $display("FAIL iv_digest: got %h want %h", bus.digest_out, ABC_DIG); end
        step();
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.msg_in    = '0;
        bus.chain_in  = '0;
`ifdef SEQ_IV_EN
        bus.first_blk = 1'b0;
`endif
        test_reset();
        test_abc();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid_round();
        test_back_to_back();
`ifdef SEQ_IV_EN
        test_iv();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
